// File: rtl/alu_issue.sv
// RV32I decode / operand-issue stage feeding alu_i.
// Decodes OP and OP-IMM words, reads operands from a 32-entry register file
// (with write-back bypass), and holds the result in one valid/ready slot.
// While the slot is stalled, held register operands track write-backs so the
// ALU never consumes a stale value.
module alu_issue #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr,
    input  logic                   wb_en,
    input  logic [4:0]             wb_addr,
    input  logic [DATA_WIDTH-1:0]  wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  rs1,
    output logic [DATA_WIDTH-1:0]  rs2,
    output logic [INSTR_WIDTH-1:0] operation,
    output logic [4:0]             rd_addr,
    output logic                   illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [INSTR_WIDTH-1:0] ALU_ADD  = INSTR_WIDTH'(0);
    localparam logic [INSTR_WIDTH-1:0] ALU_SLT  = INSTR_WIDTH'(1);
    localparam logic [INSTR_WIDTH-1:0] ALU_SLTU = INSTR_WIDTH'(2);
    localparam logic [INSTR_WIDTH-1:0] ALU_AND  = INSTR_WIDTH'(3);
    localparam logic [INSTR_WIDTH-1:0] ALU_OR   = INSTR_WIDTH'(4);
    localparam logic [INSTR_WIDTH-1:0] ALU_XOR  = INSTR_WIDTH'(5);
    localparam logic [INSTR_WIDTH-1:0] ALU_SLL  = INSTR_WIDTH'(6);
    localparam logic [INSTR_WIDTH-1:0] ALU_SRL  = INSTR_WIDTH'(7);
    localparam logic [INSTR_WIDTH-1:0] ALU_SUB  = INSTR_WIDTH'(8);
    localparam logic [INSTR_WIDTH-1:0] ALU_SRA  = INSTR_WIDTH'(9);

    logic [DATA_WIDTH-1:0] rf [32];

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] idx_a;
    logic [4:0] idx_b;
    logic       is_op;
    logic       is_op_imm;
    logic       f7_zero;
    logic       f7_alt;

    logic [DATA_WIDTH-1:0]  rd_a;
    logic [DATA_WIDTH-1:0]  rd_b;
    logic [INSTR_WIDTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]  dec_rs2;
    logic                   dec_rs2_reg;
    logic                   dec_legal;
    logic                   accept;

    // Slot bookkeeping for operand refresh while stalled.
    logic [4:0] held_idx_a;
    logic [4:0] held_idx_b;
    logic       held_a_reg;
    logic       held_b_reg;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign f7        = instr[31:25];
    assign idx_a     = instr[19:15];
    assign idx_b     = instr[24:20];
    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign f7_zero   = (f7 == F7_ZERO);
    assign f7_alt    = (f7 == F7_ALT);

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Register-file write port; x0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Operand read with same-cycle write-back bypass.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (idx_a != 5'd0) begin
            rd_a = (wb_en && (wb_addr == idx_a)) ? wb_data : rf[idx_a];
        end
        if (idx_b != 5'd0) begin
            rd_b = (wb_en && (wb_addr == idx_b)) ? wb_data : rf[idx_b];
        end
    end

    // Decode: ALU opcode, legality, and second-operand source.
    always_comb begin
        dec_op      = ALU_ADD;
        dec_rs2     = '0;
        dec_rs2_reg = 1'b0;
        dec_legal   = 1'b0;

        case (f3)
            3'b000:  dec_op = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = f7_alt ? ALU_SRA : ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
        endcase

        if (is_op) begin
            dec_legal   = f7_zero || (f7_alt && ((f3 == 3'b000) || (f3 == 3'b101)));
            dec_rs2     = rd_b;
            dec_rs2_reg = 1'b1;
        end else if (is_op_imm) begin
            if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                // Shift-immediates reuse f7 as a funct field; only SRAI may set bit 30.
                dec_legal = f7_zero || (f7_alt && (f3 == 3'b101));
                dec_rs2   = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
            end else begin
                dec_legal = 1'b1;
                dec_rs2   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
            end
        end
    end

    // Issue slot: load on accept, release on consume, refresh operands while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            rs1        <= '0;
            rs2        <= '0;
            operation  <= ALU_ADD;
            rd_addr    <= 5'd0;
            illegal    <= 1'b0;
            held_idx_a <= 5'd0;
            held_idx_b <= 5'd0;
            held_a_reg <= 1'b0;
            held_b_reg <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (dec_legal) begin
                rs1        <= rd_a;
                rs2        <= dec_rs2;
                operation  <= dec_op;
                rd_addr    <= instr[11:7];
                illegal    <= 1'b0;
                held_idx_a <= idx_a;
                held_idx_b <= idx_b;
                held_a_reg <= 1'b1;
                held_b_reg <= dec_rs2_reg;
            end else begin
                // Illegal words become ADD x0,0,0 so the ALU write lands harmlessly in x0.
                rs1        <= '0;
                rs2        <= '0;
                operation  <= ALU_ADD;
                rd_addr    <= 5'd0;
                illegal    <= 1'b1;
                held_idx_a <= 5'd0;
                held_idx_b <= 5'd0;
                held_a_reg <= 1'b0;
                held_b_reg <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid && wb_en && (wb_addr != 5'd0)) begin
            if (held_a_reg && (wb_addr == held_idx_a)) begin
                rs1 <= wb_data;
            end
            if (held_b_reg && (wb_addr == held_idx_b)) begin
                rs2 <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue: stimulus pushes hand-computed expected
// slot contents into a queue; a monitor pops and compares on each handshake.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  operation;
    logic [4:0]  rd_addr;
    logic        illegal;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   run_len = 0;
    int   max_run = 0;

    alu_issue #(.DATA_WIDTH(32), .INSTR_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .operation (operation),
        .rd_addr   (rd_addr),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [4:0] rd, input logic ill);
        exp_t e;
        e.rs1 = a;
        e.rs2 = b;
        e.op  = op;
        e.rd  = rd;
        e.ill = ill;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [31:0] w, input exp_t e);
        int n;
        n = 0;
        instr    = w;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL issue_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: compare slot contents on every handshake, track out_valid run length.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got rd_addr=%0d op=%0d, required no output",
                             rd_addr, operation);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rs1",       rs1,               e.rs1);
                    check("sb_rs2",       rs2,               e.rs2);
                    check("sb_operation", 32'(operation),    32'(e.op));
                    check("sb_rd_addr",   32'(rd_addr),      32'(e.rd));
                    check("sb_illegal",   32'(illegal),      32'(e.ill));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;
        out_ready = 1'b0;
        idle(2);
        rst_n = 1'b1;
        tick();

        // 1. Reset mid-stall discards slot and clears the register file.
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        tick();
        wb_en = 1'b0;
        instr = 32'h0050_0093; in_valid = 1'b1;     // ADDI x1,x0,5 held (out_ready=0)
        tick();
        in_valid = 1'b0;
        check("stall_valid_pre_reset", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        idle(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rs1",       rs1,            32'd0);
        check("rst_rs2",       rs2,            32'd0);
        check("rst_operation", 32'(operation), 32'd0);
        check("rst_rd_addr",   32'(rd_addr),   32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        issue(32'h0002_8433, mk(32'h0, 32'h0, 4'd0, 5'd8, 1'b0));   // ADD x8,x5,x0
        idle(2);

        // 2. Register write then ADDI with negative immediate.
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0010;
        tick();
        wb_en = 1'b0;
        issue(32'hFFF1_8213, mk(32'h10, 32'hFFFF_FFFF, 4'd0, 5'd4, 1'b0));
        check("addi_latency_valid", 32'(out_valid), 32'd1);
        idle(2);

        // 3. Same-cycle write-back bypass into SUB.
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
        issue(32'h4003_80B3, mk(32'hDEAD_BEEF, 32'h0, 4'd8, 5'd1, 1'b0));
        wb_en = 1'b0;
        idle(2);

        // 4. Stall with operand refresh; second word must not be accepted.
        out_ready = 1'b0;
        issue(32'h4063_5133, mk(32'h8000_0000, 32'h8000_0000, 4'd9, 5'd2, 1'b0));
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h8000_0000;
        tick();
        wb_en = 1'b0;
        check("stall_rs1_refresh", rs1,            32'h8000_0000);
        check("stall_rs2_refresh", rs2,            32'h8000_0000);
        check("stall_operation",   32'(operation), 32'd9);
        check("stall_in_ready",    32'(in_ready),  32'd0);
        instr = 32'h0000_04B3; in_valid = 1'b1;     // ADD x9,x0,x0 offered during stall
        idle(2);
        check("stall_hold_rd",    32'(rd_addr),   32'd2);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall_second_dropped", 32'(out_valid), 32'd0);
        idle(2);

        // 5. Back-to-back issue at full throughput.
        max_run = 0;
        issue(32'h0031_8533, mk(32'h10,          32'h10,  4'd0, 5'd10, 1'b0)); // ADD  x10,x3,x3
        issue(32'h4043_5593, mk(32'h8000_0000,   32'h4,   4'd9, 5'd11, 1'b0)); // SRAI x11,x6,4
        issue(32'h0033_B633, mk(32'hDEAD_BEEF,   32'h10,  4'd2, 5'd12, 1'b0)); // SLTU x12,x7,x3
        issue(32'h7FF1_C693, mk(32'h10,          32'h7FF, 4'd5, 5'd13, 1'b0)); // XORI x13,x3,2047
        idle(3);
        check("b2b_valid_run", 32'(max_run), 32'd4);

        // 6. Illegal words issue as ADD x0,0,0 with illegal set.
        issue(32'h0220_8033, mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b1));   // MUL
        issue(32'h0001_A283, mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b1));   // LW (opcode 0x03)
        issue(32'h4041_9713, mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b1));   // SLLI with f7=0100000
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
